// File: rtl/xain_audio_i2s.sv
// xain_audio_i2s: mixes/routes two signed 16-bit sources, attenuates with saturation,
// and serializes them as a Philips I2S stream with internally divided SCLK/LRCK.
module xain_audio_i2s #(
    parameter int SCLK_HALF_DIV = 8,
    parameter int STEREO        = 0
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [15:0] snd1,
    input  logic [15:0] snd2,
    input  logic [1:0]  atten,
    input  logic        mute,
    output logic        i2s_sclk,
    output logic        i2s_lrck,
    output logic        i2s_dat,
    output logic        frame_strobe
);
    logic [7:0]         half_cnt_q, half_cnt_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic               sclk_q, sclk_d, lrck_q, lrck_d, dat_q, dat_d, strobe_q, strobe_d;
    logic [15:0]        wl_q, wl_d, wr_q, wr_d;
    logic               wrap, fall, latch;
    logic [4:0]         pos;
    logic [3:0]         idx;
    logic [15:0]        word, mono, mix_l, mix_r;
    logic signed [16:0] sum, shr;
    logic signed [15:0] sh1, sh2;

    always_comb begin
        sum   = {snd1[15], snd1} + {snd2[15], snd2};
        shr   = sum >>> atten;
        sh1   = $signed(snd1) >>> atten;
        sh2   = $signed(snd2) >>> atten;
        mono  = (shr[16] != shr[15]) ? (shr[16] ? 16'h8000 : 16'h7fff) : shr[15:0];
        mix_l = mute ? 16'h0000 : (STEREO != 0 ? sh1 : mono);
        mix_r = mute ? 16'h0000 : (STEREO != 0 ? sh2 : mono);
    end

    always_comb begin
        wrap       = half_cnt_q == 8'(SCLK_HALF_DIV - 1);
        half_cnt_d = wrap ? 8'd0 : half_cnt_q + 8'd1;
        sclk_d     = sclk_q ^ wrap;
        fall       = wrap & sclk_q;
        latch      = fall & (bit_cnt_q == 6'd63);
        bit_cnt_d  = bit_cnt_q + {5'd0, fall};
        pos        = bit_cnt_d[4:0];
        // 16-p modulo 16 selects the MSB at p=1 down to the LSB at p=16
        idx        = 4'd0 - pos[3:0];
        word       = bit_cnt_d[5] ? wr_q : wl_q;
        lrck_d     = fall ? bit_cnt_d[5] : lrck_q;
        dat_d      = fall ? (pos != 5'd0 && pos <= 5'd16 && word[idx]) : dat_q;
        strobe_d   = latch;
        wl_d       = latch ? mix_l : wl_q;
        wr_d       = latch ? mix_r : wr_q;
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            dat_q      <= 1'b0;
            strobe_q   <= 1'b0;
            wl_q       <= '0;
            wr_q       <= '0;
        end else begin
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            strobe_q   <= strobe_d;
            wl_q       <= wl_d;
            wr_q       <= wr_d;
        end
    end

    assign i2s_sclk     = sclk_q;
    assign i2s_lrck     = lrck_q;
    assign i2s_dat      = dat_q;
    assign frame_strobe = strobe_q;
endmodule

// File: tb/tb_xain_audio_i2s.sv
// tb_xain_audio_i2s: mono (div 8) and stereo (div 1) instances driven by a shared vector
// table; a frame decoder at SCLK rises checks each frame against queued expected words.
module tb_xain_audio_i2s;
    localparam int NV = 14;
    localparam int RV = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rstn, mu, sclk, lrck, dat, fs, done;
    logic [1:0][15:0] s1, s2;
    logic [1:0][1:0]  at;
    logic [1:0]       r_s = '0;
    logic [1:0]       prev = '0;
    logic [1:0]       chk = '0;
    int               e[2], rise[2];
    logic [63:0]      fr[2];
    logic [31:0]      q0[$], q1[$];
    logic [15:0]      vs1[NV], vs2[NV];
    logic [1:0]       vat[NV];
    logic             vmu[NV];
    int               total = 0, bad = 0;
    int               d_m, slot;
    logic [31:0]      w;

    xain_audio_i2s #(.SCLK_HALF_DIV(8), .STEREO(0)) dut_mono (
        .clk(clk), .RSTn(rstn[0]), .snd1(s1[0]), .snd2(s2[0]), .atten(at[0]), .mute(mu[0]),
        .i2s_sclk(sclk[0]), .i2s_lrck(lrck[0]), .i2s_dat(dat[0]), .frame_strobe(fs[0]));

    xain_audio_i2s #(.SCLK_HALF_DIV(1), .STEREO(1)) dut_stereo (
        .clk(clk), .RSTn(rstn[1]), .snd1(s1[1]), .snd2(s2[1]), .atten(at[1]), .mute(mu[1]),
        .i2s_sclk(sclk[1]), .i2s_lrck(lrck[1]), .i2s_dat(dat[1]), .frame_strobe(fs[1]));

    // Reference: words a frame should carry given the inputs present at its latch
    function automatic logic [31:0] model(bit st, int a, int b, int sh, bit m);
        int l, r, t;
        if (m) return 32'h0;
        if (st) begin
            l = a >>> sh;
            r = b >>> sh;
        end else begin
            t = (a + b) >>> sh;
            t = t > 32767 ? 32767 : (t < -32768 ? -32768 : t);
            l = t;
            r = t;
        end
        return {l[15:0], r[15:0]};
    endfunction

    function automatic void pushq(int i, logic [31:0] v);
        if (i == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    function automatic void clrq(int i);
        if (i == 0) q0.delete(); else q1.delete();
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] popq(int i);
        return (i == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic void check(int i, string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL inst%0d %s: got %h expected %h at %0t", i, nm, act, exp, $time);
        end
    endfunction

    task automatic run(input int i);
        int d;
        d = (i != 0) ? 1 : 8;
        rstn[i] = 1'b0; mu[i] = 1'b0; at[i] = 2'd0; s1[i] = 16'h1234; s2[i] = 16'h0000;
        repeat (5) @(posedge clk);
        #1;
        clrq(i);
        pushq(i, 32'h0);
        rstn[i] = 1'b1;
        for (int k = 0; k < NV; k++) begin
            if (k == RV) begin
                repeat (2 * d * 42 + d) @(posedge clk);
                #1 rstn[i] = 1'b0;
                clrq(i);
                pushq(i, 32'h0);
                repeat (5) @(posedge clk);
                #1 rstn[i] = 1'b1;
            end
            s1[i] = vs1[k]; s2[i] = vs2[k]; at[i] = vat[k]; mu[i] = 1'b0;
            pushq(i, model(i != 0, int'($signed(vs1[k])), int'($signed(vs2[k])), int'(vat[k]), vmu[k]));
            if (vmu[k]) begin
                repeat (11 * d) @(posedge clk);
                #1 mu[i] = 1'b1;
                repeat (117 * d) @(posedge clk);
            end else begin
                repeat (128 * d) @(posedge clk);
            end
            #1;
        end
        repeat (136 * d) @(posedge clk);
        #1 done[i] = 1'b1;
    endtask

    always @(posedge clk) r_s <= rstn;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            d_m = (i != 0) ? 1 : 8;
            if (!r_s[i]) begin
                check(i, "reset_outputs", {sclk[i], lrck[i], dat[i], fs[i]}, 4'b0);
                e[i] = 0; rise[i] = 0; prev[i] = 1'b0;
            end else begin
                e[i]++;
                check(i, "sclk_phase", sclk[i], ((e[i] / d_m) % 2) != 0);
                check(i, "frame_strobe", fs[i], (e[i] % (128 * d_m)) == 0);
                if (sclk[i] && !prev[i] && !done[i]) begin
                    slot = rise[i] % 64;
                    check(i, "lrck_slot", lrck[i], slot >= 32);
                    fr[i][63 - slot] = dat[i];
                    if (slot == 63) begin
                        if (qsize(i) == 0) begin
                            check(i, "frame_unexpected", 64'd1, 64'd0);
                        end else begin
                            w = popq(i);
                            check(i, "frame_bits", fr[i], {1'b0, w[31:16], 15'd0, 1'b0, w[15:0], 15'd0});
                        end
                    end
                    rise[i]++;
                end
                prev[i] = sclk[i];
            end
            if (done[i] && !chk[i]) begin
                chk[i] = 1'b1;
                check(i, "frames_pending", 64'(qsize(i)), 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        done = '0;
        vs1[0] = 16'(30000);  vs2[0] = 16'(10000);  vat[0] = 2'd0; vmu[0] = 1'b0;
        vs1[1] = 16'(-30000); vs2[1] = 16'(-10000); vat[1] = 2'd0; vmu[1] = 1'b0;
        vs1[2] = 16'(100);    vs2[2] = 16'(-300);   vat[2] = 2'd0; vmu[2] = 1'b0;
        vs1[3] = 16'h4000;    vs2[3] = 16'h0000;    vat[3] = 2'd3; vmu[3] = 1'b0;
        vs1[4] = 16'h8000;    vs2[4] = 16'h8000;    vat[4] = 2'd2; vmu[4] = 1'b0;
        vs1[5] = 16'h8001;    vs2[5] = 16'h1234;    vat[5] = 2'd0; vmu[5] = 1'b0;
        vs1[6] = 16'h1234;    vs2[6] = 16'h0100;    vat[6] = 2'd1; vmu[6] = 1'b1;
        vs1[7] = 16'h1234;    vs2[7] = 16'h0100;    vat[7] = 2'd1; vmu[7] = 1'b0;
        for (int k = 8; k < NV; k++) begin
            vs1[k] = 16'($urandom);
            vs2[k] = 16'($urandom);
            vat[k] = 2'($urandom_range(0, 3));
            vmu[k] = 1'b0;
        end
        fork
            run(0);
            run(1);
        join
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
